// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state
// encoding and the values every register takes under reset.
package seq_divider_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam state_e RST_STATE = ST_IDLE;
  localparam logic   RST_FLAG  = 1'b0;
  localparam logic   RST_BIT   = 1'b0;

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_bit_o
);

  logic [WIDTH:0]   trial_s;
  logic [WIDTH-1:0] diff_s;

  // The trial value needs WIDTH+1 bits, but when it is at least the divisor
  // the difference is below the divisor, so the low WIDTH bits are exact.
  always_comb begin
    trial_s = {rem_i, bit_i};
    q_bit_o = (trial_s >= {1'b0, divisor_i});
    diff_s  = trial_s[WIDTH-1:0] - divisor_i;
    if (q_bit_o) begin
      rem_o = diff_s;
    end else begin
      rem_o = trial_s[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned divider with a start/busy/done handshake; produces one
// quotient bit per clock using a single div_step.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             dbz
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] part_q, part_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] step_rem_s;
  logic             step_bit_s;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (part_q),
    .bit_i     (dvd_q[WIDTH-1]),
    .divisor_i (dvs_q),
    .rem_o     (step_rem_s),
    .q_bit_o   (step_bit_s)
  );

  // Next-state and datapath update. dvd_q doubles as the quotient
  // accumulator: dividend bits shift out the top, quotient bits shift in.
  // A zero divisor takes a single dummy RUN cycle so done lands one edge
  // after accept, with the step result overridden on the way to DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    part_d  = part_q;
    dz_d    = dz_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          dvd_d   = dividend;
          dvs_d   = divisor;
          part_d  = {WIDTH{1'b0}};
          dbz_d   = 1'b0;
          dz_d    = (divisor == {WIDTH{1'b0}});
          if (divisor == {WIDTH{1'b0}}) begin
            cnt_d = CNT_W'(1);
          end else begin
            cnt_d = CNT_W'(WIDTH);
          end
          state_d = ST_RUN;
          busy_d  = 1'b1;
        end else begin
          busy_d  = 1'b0;
        end
      end
      ST_RUN: begin
        part_d = step_rem_s;
        dvd_d  = {dvd_q[WIDTH-2:0], step_bit_s};
        cnt_d  = cnt_q - CNT_W'(1);
        busy_d = 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          if (dz_q) begin
            quo_d = {WIDTH{1'b1}};
            rem_d = dvd_q;
            dbz_d = 1'b1;
          end else begin
            quo_d = {dvd_q[WIDTH-2:0], step_bit_s};
            rem_d = step_rem_s;
            dbz_d = 1'b0;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= RST_STATE;
      cnt_q   <= {CNT_W{RST_BIT}};
      dvd_q   <= {WIDTH{RST_BIT}};
      dvs_q   <= {WIDTH{RST_BIT}};
      part_q  <= {WIDTH{RST_BIT}};
      dz_q    <= RST_FLAG;
      quo_q   <= {WIDTH{RST_BIT}};
      rem_q   <= {WIDTH{RST_BIT}};
      dbz_q   <= RST_FLAG;
      busy_q  <= RST_FLAG;
      done_q  <= RST_FLAG;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      part_q  <= part_d;
      dz_q    <= dz_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbz       = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: table of single operations at WIDTH=8,
// hand-written corner sequences, and a back-to-back sweep at WIDTH=4.
module tb_seq_divider;

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] eq;
    logic [7:0] er;
    logic       ed;
    int         lat;
  } vec_t;

  logic       clk;
  logic       rst_b;
  logic       start8, start4;
  logic [7:0] dividend8, divisor8, quotient8, remainder8;
  logic [3:0] dividend4, divisor4, quotient4, remainder4;
  logic       busy8, done8, dbz8, busy4, done4, dbz4;

  int   total;
  int   bad;
  int   done8_cnt;
  int   done4_cnt;
  int   cyc;
  exp_t sb8[$];
  exp_t sb4[$];

  seq_divider #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_b(rst_b), .start(start8), .dividend(dividend8), .divisor(divisor8),
    .quotient(quotient8), .remainder(remainder8), .busy(busy8), .done(done8), .dbz(dbz8)
  );

  seq_divider #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_b(rst_b), .start(start4), .dividend(dividend4), .divisor(divisor4),
    .quotient(quotient4), .remainder(remainder4), .busy(busy4), .done(done4), .dbz(dbz4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Scoreboard for the 8-bit instance: every done pulse pops one expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_b === 1'b1 && done8 === 1'b1) begin
      done8_cnt++;
      if (sb8.size() == 0) begin
        chk("extra_done8", 32'd1, 32'd0);
      end else begin
        e = sb8.pop_front();
        chk("quotient8", {24'd0, quotient8}, e.q);
        chk("remainder8", {24'd0, remainder8}, e.r);
        chk("dbz8", {31'd0, dbz8}, {31'd0, e.dbz});
      end
    end
  end

  // Scoreboard for the 4-bit instance.
  always @(negedge clk) begin
    exp_t e;
    if (rst_b === 1'b1 && done4 === 1'b1) begin
      done4_cnt++;
      if (sb4.size() == 0) begin
        chk("extra_done4", 32'd1, 32'd0);
      end else begin
        e = sb4.pop_front();
        chk("quotient4", {28'd0, quotient4}, e.q);
        chk("remainder4", {28'd0, remainder4}, e.r);
        chk("dbz4", {31'd0, dbz4}, {31'd0, e.dbz});
      end
    end
  end

  // One operation on the 8-bit instance, checking latency, busy and hold.
  task automatic do_op(input vec_t v, input string nm);
    int edges;
    int busy_cnt;
    @(negedge clk);
    dividend8 = v.a;
    divisor8  = v.b;
    start8    = 1'b1;
    sb8.push_back('{q: {24'd0, v.eq}, r: {24'd0, v.er}, dbz: v.ed});
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    start8    = 1'b0;
    dividend8 = 8'($urandom);
    divisor8  = 8'($urandom);
    busy_cnt  = (busy8 === 1'b1) ? 1 : 0;
    while (done8 !== 1'b1 && edges < 40) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (busy8 === 1'b1) busy_cnt++;
    end
    chk({nm, "_latency"}, 32'(edges), 32'(v.lat));
    chk({nm, "_busy_cycles"}, 32'(busy_cnt), 32'(v.lat));
    @(negedge clk);
    chk({nm, "_done_low"}, {31'd0, done8}, 32'd0);
    chk({nm, "_busy_low"}, {31'd0, busy8}, 32'd0);
    chk({nm, "_q_held"}, {24'd0, quotient8}, {24'd0, v.eq});
    chk({nm, "_dbz_held"}, {31'd0, dbz8}, {31'd0, v.ed});
  endtask

  vec_t vecs[10];
  int   d8_before;
  int   acc_cyc[16];
  int   guard;

  initial begin
    total = 0; bad = 0; done8_cnt = 0; done4_cnt = 0; cyc = 0;
    start8 = 1'b0; start4 = 1'b0;
    dividend8 = 8'd0; divisor8 = 8'd0; dividend4 = 4'd0; divisor4 = 4'd3;
    rst_b = 1'b0;

    vecs[0] = '{a: 8'd200, b: 8'd3,   eq: 8'd66,  er: 8'd2,  ed: 1'b0, lat: 9};
    vecs[1] = '{a: 8'd7,   b: 8'd9,   eq: 8'd0,   er: 8'd7,  ed: 1'b0, lat: 9};
    vecs[2] = '{a: 8'd255, b: 8'd1,   eq: 8'd255, er: 8'd0,  ed: 1'b0, lat: 9};
    vecs[3] = '{a: 8'd255, b: 8'd255, eq: 8'd1,   er: 8'd0,  ed: 1'b0, lat: 9};
    vecs[4] = '{a: 8'd13,  b: 8'd0,   eq: 8'd255, er: 8'd13, ed: 1'b1, lat: 2};
    vecs[5] = '{a: 8'd10,  b: 8'd5,   eq: 8'd2,   er: 8'd0,  ed: 1'b0, lat: 9};
    vecs[6] = '{a: 8'd0,   b: 8'd7,   eq: 8'd0,   er: 8'd0,  ed: 1'b0, lat: 9};
    vecs[7] = '{a: 8'd128, b: 8'd16,  eq: 8'd8,   er: 8'd0,  ed: 1'b0, lat: 9};
    vecs[8] = '{a: 8'd1,   b: 8'd255, eq: 8'd0,   er: 8'd1,  ed: 1'b0, lat: 9};
    vecs[9] = '{a: 8'd254, b: 8'd128, eq: 8'd1,   er: 8'd126, ed: 1'b0, lat: 9};

    repeat (2) @(negedge clk);
    chk("rst_quotient8", {24'd0, quotient8}, 32'd0);
    chk("rst_remainder8", {24'd0, remainder8}, 32'd0);
    chk("rst_busy8", {31'd0, busy8}, 32'd0);
    chk("rst_done8", {31'd0, done8}, 32'd0);
    chk("rst_dbz8", {31'd0, dbz8}, 32'd0);
    chk("rst_quotient4", {28'd0, quotient4}, 32'd0);
    rst_b = 1'b1;

    for (int i = 0; i < 10; i++) begin
      do_op(vecs[i], $sformatf("vec%0d", i));
    end

    // Start pulsed during RUN must be ignored.
    d8_before = done8_cnt;
    @(negedge clk);
    dividend8 = 8'd100; divisor8 = 8'd7; start8 = 1'b1;
    sb8.push_back('{q: 32'd14, r: 32'd2, dbz: 1'b0});
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    repeat (2) @(negedge clk);
    dividend8 = 8'd50; divisor8 = 8'd5; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (25) @(negedge clk);
    chk("ignored_start_done_count", 32'(done8_cnt - d8_before), 32'd1);
    chk("ignored_start_busy", {31'd0, busy8}, 32'd0);

    // Asynchronous reset in the middle of RUN discards the operation.
    @(negedge clk);
    dividend8 = 8'd200; divisor8 = 8'd3; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_b = 1'b0;
    #1;
    chk("async_rst_quotient", {24'd0, quotient8}, 32'd0);
    chk("async_rst_remainder", {24'd0, remainder8}, 32'd0);
    chk("async_rst_busy", {31'd0, busy8}, 32'd0);
    chk("async_rst_done", {31'd0, done8}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_b = 1'b1;
    d8_before = done8_cnt;
    repeat (15) @(negedge clk);
    chk("no_done_after_rst", 32'(done8_cnt - d8_before), 32'd0);
    do_op('{a: 8'd9, b: 8'd2, eq: 8'd4, er: 8'd1, ed: 1'b0, lat: 9}, "after_rst");

    // WIDTH=4 back-to-back sweep with start held high.
    @(negedge clk);
    start4 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      guard = 0;
      while (busy4 !== 1'b0 && guard < 30) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 30) chk("sweep_wait_timeout", 32'd1, 32'd0);
      dividend4 = 4'(i);
      sb4.push_back('{q: 32'(i / 3), r: 32'(i % 3), dbz: 1'b0});
      @(posedge clk);
      acc_cyc[i] = cyc;
      #1;
      if (i == 15) start4 = 1'b0;
      if (i > 0) chk($sformatf("sweep_period%0d", i), 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd6);
    end
    guard = 0;
    while ((sb4.size() != 0 || sb8.size() != 0) && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    chk("sb4_drained", 32'(sb4.size()), 32'd0);
    chk("sb8_drained", 32'(sb8.size()), 32'd0);
    chk("sweep_done_count", 32'(done4_cnt), 32'd16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
